// File: rtl/idma_transport_arb_pkg.sv
// Shared helpers for the transport arbiter: ID width derivation and the
// wrapping round-robin search used by the read arbiter.
package idma_transport_arb_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req[n-1:0] at or above ptr, wrapping; -1 when none.
  // Scanned from the far end so the closest candidate is written last.
  function automatic int rr_search(input logic [31:0] req, input int ptr, input int n);
    int res;
    int idx;
    res = -1;
    for (int i = 31; i >= 0; i--) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/idma_arb_id_fifo.sv
// Small channel-ID FIFO; pointers wrap modulo Depth, fill level kept
// in a separate counter so non-power-of-two depths work.
module idma_arb_id_fifo #(
  parameter int Depth   = 4,
  parameter int IdWidth = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [IdWidth-1:0] data_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [IdWidth-1:0] head_o
);
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = $clog2(Depth) + 1;

  logic [IdWidth-1:0]  mem_q [Depth];
  logic [IdWidth-1:0]  mem_d [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
    end
    cnt_d = cnt_q + CntWidth'(push_i) - CntWidth'(pop_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/idma_transport_arbiter.sv
// Shares one read/write transport between NumChan channels: round-robin on
// reads, writes forced into the same channel order, responses routed back.
module idma_transport_arbiter
  import idma_transport_arb_pkg::*;
#(
  parameter int NumChan    = 2,
  parameter int RReqWidth  = 64,
  parameter int WReqWidth  = 64,
  parameter int RRspWidth  = 8,
  parameter int WRspWidth  = 8,
  parameter int OrderDepth = 4,
  parameter int RspDepth   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumChan*RReqWidth-1:0] chan_r_req_i,
  input  logic [NumChan-1:0]           chan_r_valid_i,
  output logic [NumChan-1:0]           chan_r_ready_o,
  input  logic [NumChan*WReqWidth-1:0] chan_w_req_i,
  input  logic [NumChan-1:0]           chan_w_valid_i,
  output logic [NumChan-1:0]           chan_w_ready_o,
  output logic [RRspWidth-1:0]         chan_r_rsp_o,
  output logic [NumChan-1:0]           chan_r_rsp_valid_o,
  input  logic [NumChan-1:0]           chan_r_rsp_ready_i,
  output logic [WRspWidth-1:0]         chan_w_rsp_o,
  output logic [NumChan-1:0]           chan_w_rsp_valid_o,
  input  logic [NumChan-1:0]           chan_w_rsp_ready_i,
  output logic [RReqWidth-1:0]         r_dp_req_o,
  output logic                         r_dp_valid_o,
  input  logic                         r_dp_ready_i,
  input  logic [RRspWidth-1:0]         r_dp_rsp_i,
  input  logic                         r_dp_rsp_valid_i,
  output logic                         r_dp_rsp_ready_o,
  output logic [WReqWidth-1:0]         w_dp_req_o,
  output logic                         w_dp_valid_o,
  input  logic                         w_dp_ready_i,
  input  logic [WRspWidth-1:0]         w_dp_rsp_i,
  input  logic                         w_dp_rsp_valid_i,
  output logic                         w_dp_rsp_ready_o,
  output logic                         busy_o
);
  localparam int IdWidth = idx_width(NumChan);

  logic [IdWidth-1:0] rr_q, rr_d, gnt_q, gnt_d, gnt;
  logic               lock_q, lock_d;
  logic               gnt_vld, r_valid, r_hs;
  logic               w_avail, w_valid, w_hs, r_rsp_pop, w_rsp_pop;
  logic               ord_full, ord_empty, rrsp_full, rrsp_empty, wrsp_full, wrsp_empty;
  logic [IdWidth-1:0] ord_head, rrsp_head, wrsp_head;
  int                 search;

  // A locked grant is never re-arbitrated; FIFOs cannot fill while locked
  // because only a read handshake pushes them.
  always_comb begin
    search  = rr_search(32'(chan_r_valid_i), int'(rr_q), NumChan);
    gnt     = lock_q ? gnt_q : IdWidth'(search);
    gnt_vld = lock_q ? chan_r_valid_i[gnt_q] : (search >= 0);
    r_valid = !rst_i && !ord_full && !rrsp_full && gnt_vld;
    r_hs    = r_valid && r_dp_ready_i;
    rr_d    = rr_q;
    lock_d  = lock_q;
    gnt_d   = gnt_q;
    if (r_hs) begin
      lock_d = 1'b0;
      rr_d   = (gnt == IdWidth'(NumChan - 1)) ? '0 : gnt + IdWidth'(1);
    end else if (r_valid) begin
      lock_d = 1'b1;
      gnt_d  = gnt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      gnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      gnt_q  <= gnt_d;
      lock_q <= lock_d;
    end
  end

  assign r_dp_valid_o = r_valid;
  assign r_dp_req_o   = r_valid ? chan_r_req_i[gnt*RReqWidth +: RReqWidth] : '0;

  assign w_avail      = !ord_empty && !wrsp_full;
  assign w_valid      = w_avail && chan_w_valid_i[ord_head];
  assign w_hs         = w_valid && w_dp_ready_i;
  assign w_dp_valid_o = w_valid;
  assign w_dp_req_o   = w_valid ? chan_w_req_i[ord_head*WReqWidth +: WReqWidth] : '0;

  assign r_dp_rsp_ready_o = !rrsp_empty && chan_r_rsp_ready_i[rrsp_head];
  assign w_dp_rsp_ready_o = !wrsp_empty && chan_w_rsp_ready_i[wrsp_head];
  assign r_rsp_pop        = r_dp_rsp_valid_i && r_dp_rsp_ready_o;
  assign w_rsp_pop        = w_dp_rsp_valid_i && w_dp_rsp_ready_o;
  assign chan_r_rsp_o     = rrsp_empty ? '0 : r_dp_rsp_i;
  assign chan_w_rsp_o     = wrsp_empty ? '0 : w_dp_rsp_i;

  for (genvar gi = 0; gi < NumChan; gi++) begin : g_chan
    assign chan_r_ready_o[gi]     = r_valid && r_dp_ready_i && (gnt == IdWidth'(gi));
    assign chan_w_ready_o[gi]     = w_avail && w_dp_ready_i && (ord_head == IdWidth'(gi));
    assign chan_r_rsp_valid_o[gi] = !rrsp_empty && r_dp_rsp_valid_i && (rrsp_head == IdWidth'(gi));
    assign chan_w_rsp_valid_o[gi] = !wrsp_empty && w_dp_rsp_valid_i && (wrsp_head == IdWidth'(gi));
  end

  assign busy_o = lock_q || !ord_empty || !rrsp_empty || !wrsp_empty;

  idma_arb_id_fifo #(.Depth(OrderDepth), .IdWidth(IdWidth)) i_order_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(r_hs), .data_i(gnt), .pop_i(w_hs),
    .full_o(ord_full), .empty_o(ord_empty), .head_o(ord_head)
  );

  idma_arb_id_fifo #(.Depth(RspDepth), .IdWidth(IdWidth)) i_r_rsp_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(r_hs), .data_i(gnt), .pop_i(r_rsp_pop),
    .full_o(rrsp_full), .empty_o(rrsp_empty), .head_o(rrsp_head)
  );

  idma_arb_id_fifo #(.Depth(RspDepth), .IdWidth(IdWidth)) i_w_rsp_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(w_hs), .data_i(ord_head), .pop_i(w_rsp_pop),
    .full_o(wrsp_full), .empty_o(wrsp_empty), .head_o(wrsp_head)
  );

  a_r_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_dp_valid_o && !r_dp_ready_i) |=> $stable(r_dp_req_o));
  a_r_rsp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
    !(r_dp_rsp_valid_i && rrsp_empty));
  a_w_rsp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_dp_rsp_valid_i && wrsp_empty));

endmodule

// File: tb/tb_idma_transport_arbiter.sv
// Table-driven cycle checks plus a scoreboard on every transport handshake
// and every routed response.
module tb_idma_transport_arbiter;
  localparam int NumChan = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [127:0]  chan_r_req_i, chan_w_req_i;
  logic [1:0]    chan_r_valid_i, chan_r_ready_o, chan_w_valid_i, chan_w_ready_o;
  logic [7:0]    chan_r_rsp_o, chan_w_rsp_o;
  logic [1:0]    chan_r_rsp_valid_o, chan_r_rsp_ready_i, chan_w_rsp_valid_o, chan_w_rsp_ready_i;
  logic [63:0]   r_dp_req_o, w_dp_req_o;
  logic          r_dp_valid_o, r_dp_ready_i, w_dp_valid_o, w_dp_ready_i;
  logic [7:0]    r_dp_rsp_i, w_dp_rsp_i;
  logic          r_dp_rsp_valid_i, r_dp_rsp_ready_o, w_dp_rsp_valid_i, w_dp_rsp_ready_o;
  logic          busy_o;

  idma_transport_arbiter #(
    .NumChan(NumChan), .RReqWidth(64), .WReqWidth(64), .RRspWidth(8), .WRspWidth(8),
    .OrderDepth(4), .RspDepth(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .chan_r_req_i(chan_r_req_i), .chan_r_valid_i(chan_r_valid_i), .chan_r_ready_o(chan_r_ready_o),
    .chan_w_req_i(chan_w_req_i), .chan_w_valid_i(chan_w_valid_i), .chan_w_ready_o(chan_w_ready_o),
    .chan_r_rsp_o(chan_r_rsp_o), .chan_r_rsp_valid_o(chan_r_rsp_valid_o),
    .chan_r_rsp_ready_i(chan_r_rsp_ready_i),
    .chan_w_rsp_o(chan_w_rsp_o), .chan_w_rsp_valid_o(chan_w_rsp_valid_o),
    .chan_w_rsp_ready_i(chan_w_rsp_ready_i),
    .r_dp_req_o(r_dp_req_o), .r_dp_valid_o(r_dp_valid_o), .r_dp_ready_i(r_dp_ready_i),
    .r_dp_rsp_i(r_dp_rsp_i), .r_dp_rsp_valid_i(r_dp_rsp_valid_i), .r_dp_rsp_ready_o(r_dp_rsp_ready_o),
    .w_dp_req_o(w_dp_req_o), .w_dp_valid_o(w_dp_valid_o), .w_dp_ready_i(w_dp_ready_i),
    .w_dp_rsp_i(w_dp_rsp_i), .w_dp_rsp_valid_i(w_dp_rsp_valid_i), .w_dp_rsp_ready_o(w_dp_rsp_ready_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rv;  logic rrdy; logic [1:0] wv; logic wrdy;
    logic e_rvalid;  logic [1:0] e_rready;
    logic e_wvalid;  logic [1:0] e_wready;
    logic e_busy;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int unsigned exp_r_q[$], exp_w_q[$], exp_rrsp_q[$], exp_wrsp_q[$];

  function automatic logic [63:0] rreq_of(input int unsigned c);
    return 64'hA5A5_0000_1234_0000 + 64'(c) * 64'h101;
  endfunction

  function automatic logic [63:0] wreq_of(input int unsigned c);
    return 64'h5A5A_0000_8765_0000 + 64'(c) * 64'h11;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: handshake seen, none expected", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    r_dp_rsp_i = r_dp_rsp_i + 8'd3;
    w_dp_rsp_i = w_dp_rsp_i + 8'd5;
  endtask

  task automatic idle();
    chan_r_valid_i = '0; r_dp_ready_i = 1'b0;
    chan_w_valid_i = '0; w_dp_ready_i = 1'b0;
    r_dp_rsp_valid_i = 1'b0; chan_r_rsp_ready_i = '0;
    w_dp_rsp_valid_i = 1'b0; chan_w_rsp_ready_i = '0;
  endtask

  // Drive one vector, check combinational outputs mid-cycle, record
  // expected handshakes for the scoreboard, then advance one clock.
  task automatic apply(input vec_t v, input string tag);
    int unsigned id;
    chan_r_valid_i = v.rv; r_dp_ready_i = v.rrdy;
    chan_w_valid_i = v.wv; w_dp_ready_i = v.wrdy;
    #2;
    check({tag, ".r_valid"}, 64'(r_dp_valid_o), 64'(v.e_rvalid));
    check({tag, ".r_ready"}, 64'(chan_r_ready_o), 64'(v.e_rready));
    check({tag, ".w_valid"}, 64'(w_dp_valid_o), 64'(v.e_wvalid));
    check({tag, ".w_ready"}, 64'(chan_w_ready_o), 64'(v.e_wready));
    check({tag, ".busy"}, 64'(busy_o), 64'(v.e_busy));
    if (v.e_rvalid && v.rrdy) begin
      id = v.e_rready[1] ? 1 : 0;
      exp_r_q.push_back(id);
      exp_rrsp_q.push_back(id);
    end
    if (v.e_wvalid && v.wrdy) begin
      id = v.e_wready[1] ? 1 : 0;
      exp_w_q.push_back(id);
      exp_wrsp_q.push_back(id);
    end
    $display("vec %s rv=%b wv=%b -> r_ready=%b w_ready=%b busy=%b",
             tag, v.rv, v.wv, chan_r_ready_o, chan_w_ready_o, busy_o);
    step();
  endtask

  // Scoreboard: inputs are stable from posedge+1, so the negedge sees the
  // values that the next posedge will commit.
  always @(negedge clk) begin
    int unsigned id;
    if (!rst_i) begin
      if (r_dp_valid_o && r_dp_ready_i) begin
        if (exp_r_q.size() == 0) unexpected("r_dp_hs");
        else begin
          id = exp_r_q.pop_front();
          check("r_dp_req", r_dp_req_o, rreq_of(id));
          $display("txn r_dp ch%0d req=0x%0h", id, r_dp_req_o);
        end
      end
      if (w_dp_valid_o && w_dp_ready_i) begin
        if (exp_w_q.size() == 0) unexpected("w_dp_hs");
        else begin
          id = exp_w_q.pop_front();
          check("w_dp_req", w_dp_req_o, wreq_of(id));
          $display("txn w_dp ch%0d req=0x%0h", id, w_dp_req_o);
        end
      end
      if (r_dp_rsp_valid_i && r_dp_rsp_ready_o) begin
        if (exp_rrsp_q.size() == 0) unexpected("r_rsp_hs");
        else begin
          id = exp_rrsp_q.pop_front();
          check("r_rsp_onehot", 64'(chan_r_rsp_valid_o), 64'(1) << id);
          check("r_rsp_data", 64'(chan_r_rsp_o), 64'(r_dp_rsp_i));
          $display("txn r_rsp ch%0d onehot=%b", id, chan_r_rsp_valid_o);
        end
      end
      if (w_dp_rsp_valid_i && w_dp_rsp_ready_o) begin
        if (exp_wrsp_q.size() == 0) unexpected("w_rsp_hs");
        else begin
          id = exp_wrsp_q.pop_front();
          check("w_rsp_onehot", 64'(chan_w_rsp_valid_o), 64'(1) << id);
          check("w_rsp_data", 64'(chan_w_rsp_o), 64'(w_dp_rsp_i));
          $display("txn w_rsp ch%0d onehot=%b", id, chan_w_rsp_valid_o);
        end
      end
    end
  end

  vec_t tab1[14];
  vec_t tab2[8];

  initial begin
    //          rv    rrdy  wv    wrdy  rvld  rrdy_o wvld  wrdy_o busy
    tab1 = '{
      '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0},
      '{2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0},
      '{2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 1'b0, 2'b01, 1'b1},
      '{2'b11, 1'b1, 2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1},
      '{2'b11, 1'b1, 2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1},
      '{2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1},
      '{2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1},
      '{2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1},
      '{2'b11, 1'b1, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b1},
      '{2'b11, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1},
      '{2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1},
      '{2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 1'b1},
      '{2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 2'b10, 1'b1},
      '{2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10, 1'b1}
    };
    tab2 = '{
      '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0},
      '{2'b11, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0},
      '{2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1},
      '{2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1},
      '{2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1},
      '{2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1},
      '{2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 1'b1},
      '{2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1}
    };

    chan_r_req_i = {rreq_of(1), rreq_of(0)};
    chan_w_req_i = {wreq_of(1), wreq_of(0)};
    r_dp_rsp_i = 8'h10;
    w_dp_rsp_i = 8'h80;
    idle();
    rst_i = 1'b1;
    #2;
    check("rst.busy", 64'(busy_o), 64'd0);
    check("rst.r_rsp_ready", 64'(r_dp_rsp_ready_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Round robin, write ordering, read stall, order-FIFO full blocking
    for (int i = 0; i < 14; i++) apply(tab1[i], $sformatf("t1[%0d]", i));

    // Drain remaining writes: order FIFO holds 1,0,1
    idle();
    foreach (exp_w_q[i]) ;
    exp_w_q.push_back(1); exp_w_q.push_back(0); exp_w_q.push_back(1);
    exp_wrsp_q.push_back(1); exp_wrsp_q.push_back(0); exp_wrsp_q.push_back(1);
    chan_w_valid_i = 2'b11; w_dp_ready_i = 1'b1;
    repeat (3) step();
    idle();
    #1;
    check("drain.w_valid", 64'(w_dp_valid_o), 64'd0);

    // Read responses; stall while the head belongs to ch1 and ch1 is not ready
    r_dp_rsp_valid_i = 1'b1; chan_r_rsp_ready_i = 2'b11;
    step();
    chan_r_rsp_ready_i = 2'b01;
    #1;
    check("rsp_stall.ready", 64'(r_dp_rsp_ready_o), 64'd0);
    check("rsp_stall.onehot", 64'(chan_r_rsp_valid_o), 64'b10);
    step();
    chan_r_rsp_ready_i = 2'b11;
    repeat (6) step();
    r_dp_rsp_valid_i = 1'b0;
    w_dp_rsp_valid_i = 1'b1; chan_w_rsp_ready_i = 2'b11;
    repeat (7) step();
    idle();
    #1;
    check("drained.busy", 64'(busy_o), 64'd0);
    check("drained.r_rsp_left", 64'(exp_rrsp_q.size()), 64'd0);
    check("drained.w_rsp_left", 64'(exp_wrsp_q.size()), 64'd0);

    // Two reads outstanding plus a locked grant on ch1, then reset
    chan_r_valid_i = 2'b10; r_dp_ready_i = 1'b1;
    exp_r_q.push_back(1); exp_rrsp_q.push_back(1);
    step();
    chan_r_valid_i = 2'b01;
    exp_r_q.push_back(0); exp_rrsp_q.push_back(0);
    step();
    chan_r_valid_i = 2'b10; r_dp_ready_i = 1'b0;
    step();
    check("prerst.busy", 64'(busy_o), 64'd1);
    check("prerst.r_req", r_dp_req_o, rreq_of(1));
    rst_i = 1'b1;
    chan_w_valid_i = 2'b11; w_dp_ready_i = 1'b1;
    r_dp_rsp_valid_i = 1'b1; chan_r_rsp_ready_i = 2'b11;
    #1;
    check("inrst.r_valid", 64'(r_dp_valid_o), 64'd0);
    check("inrst.r_ready", 64'(chan_r_ready_o), 64'd0);
    check("inrst.r_req", r_dp_req_o, 64'd0);
    check("inrst.w_valid", 64'(w_dp_valid_o), 64'd0);
    check("inrst.w_ready", 64'(chan_w_ready_o), 64'd0);
    check("inrst.r_rsp_valid", 64'(chan_r_rsp_valid_o), 64'd0);
    check("inrst.r_rsp_ready", 64'(r_dp_rsp_ready_o), 64'd0);
    check("inrst.busy", 64'(busy_o), 64'd0);
    exp_r_q.delete(); exp_w_q.delete(); exp_rrsp_q.delete(); exp_wrsp_q.delete();
    idle();
    step();
    rst_i = 1'b0;

    // Post-reset: first grant ch0, then fill order FIFO from ch0 and unblock
    for (int i = 0; i < 8; i++) apply(tab2[i], $sformatf("t2[%0d]", i));
    idle();
    #1;
    check("end.r_pending", 64'(exp_r_q.size()), 64'd0);
    check("end.w_pending", 64'(exp_w_q.size()), 64'd0);
    check("end.busy", 64'(busy_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/idma_transport_arbiter.md
Name: idma_transport_arbiter

Overview:
- Shares one read/write transport layer between NumChan backend channels.
- Round-robin arbitrates read-datapath requests and records each grant in an order FIFO.
- Forces write-datapath requests to follow the same channel order, so the shift buffer sees matched read/write pairs.
- Routes read and write datapath responses back to the issuing channel in order.

Parameters:
- NumChan, 2, number of requesting channels (≥2).
- RReqWidth, 64, flattened read dp request width.
- WReqWidth, 64, flattened write dp request width.
- RRspWidth, 8, flattened read dp response width.
- WRspWidth, 8, flattened write dp response width.
- OrderDepth, 4, max reads granted whose write is not yet issued.
- RspDepth, 8, max issued requests awaiting a response, per direction.
- Derived IdWidth = max(1, clog2(NumChan)).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- chan_r_req_i  in  NumChan*RReqWidth  per-channel read dp requests.
- chan_r_valid_i  in  NumChan  read request valid.
- chan_r_ready_o  out  NumChan  read request ready.
- chan_w_req_i  in  NumChan*WReqWidth  per-channel write dp requests.
- chan_w_valid_i  in  NumChan  write request valid.
- chan_w_ready_o  out  NumChan  write request ready.
- chan_r_rsp_o  out  RRspWidth  read response, broadcast to all channels.
- chan_r_rsp_valid_o  out  NumChan  read response valid, one-hot.
- chan_r_rsp_ready_i  in  NumChan  read response ready.
- chan_w_rsp_o  out  WRspWidth  write response, broadcast to all channels.
- chan_w_rsp_valid_o  out  NumChan  write response valid, one-hot.
- chan_w_rsp_ready_i  in  NumChan  write response ready.
- r_dp_req_o / r_dp_valid_o / r_dp_ready_i  out/out/in  RReqWidth/1/1  read request to transport.
- r_dp_rsp_i / r_dp_rsp_valid_i / r_dp_rsp_ready_o  in/in/out  RRspWidth/1/1  read response from transport.
- w_dp_req_o / w_dp_valid_o / w_dp_ready_i  out/out/in  WReqWidth/1/1  write request to transport.
- w_dp_rsp_i / w_dp_rsp_valid_i / w_dp_rsp_ready_o  in/in/out  WRspWidth/1/1  write response from transport.
- busy_o  out  1  any grant lock set or any FIFO non-empty.

Behaviour:
- Reset (rst_i high, asynchronous):
  - All FIFOs emptied; rr_q=0; lock_q=0.
  - All valid/ready outputs 0; busy_o=0; data outputs 0.
  - Reset mid-transfer drops all state; no response is routed afterwards for pre-reset requests.
- Read arbitration:
  - Eligible only when order FIFO and r-rsp FIFO are both not full.
  - If lock_q=0, grant the first valid channel scanning from rr_q upward, with wrap-around.
  - r_dp_valid_o=1 and r_dp_req_o=granted channel's request, combinationally.
  - If r_dp_ready_i=0, set lock_q=1 and hold the grant ID in gnt_q; the grant is not re-evaluated until handshake.
  - chan_r_ready_o[g] = r_dp_ready_i for the granted channel only.
  - On handshake: push g into order FIFO and r-rsp FIFO; rr_q = (g+1) mod NumChan; lock_q=0.
  - Zero-latency path; one grant per cycle maximum.
- Write sequencing:
  - Order FIFO head h selects the channel. w_dp_valid_o = !order_empty & chan_w_valid_i[h] & !wrsp_full.
  - chan_w_ready_o[h] = w_dp_ready_i & !wrsp_full.
  - Other channels' write valids are ignored and see ready=0.
  - On handshake: pop order FIFO, push h into w-rsp FIFO.
  - No fall-through: an ID pushed in cycle n is usable from cycle n+1.
- Response routing:
  - r-rsp FIFO head selects the one-hot chan_r_rsp_valid_o = r_dp_rsp_valid_i & !empty.
  - r_dp_rsp_ready_o = chan_r_rsp_ready_i[head] & !empty; pop on handshake.
  - Write responses identical via the w-rsp FIFO.
  - A response arriving with its FIFO empty is stalled (ready=0); the assertion fires.
  - Exactly one response per request, per direction.
- FIFOs:
  - Push on full is never attempted; blocked by the gating above.
  - Simultaneous push and pop are allowed at any fill level except push-on-full.
  - Pointers wrap modulo depth; the count is tracked separately (clog2(depth)+1 bits).
- Assertions:
  - No push on full, no pop on empty.
  - r_dp_req_o stable while r_dp_valid_o & !r_dp_ready_i.

Decomposition:
- Package idma_transport_arb_pkg holds:
  - function idx_width(n).
  - round-robin search function (first set bit from pointer, wrapping).
- Sub-module idma_arb_id_fifo (params Depth, IdWidth; push/pop/full/empty/head, async active-high reset).
- idma_arb_id_fifo is instantiated three times: order, r-rsp, w-rsp.

Test Plan:
- Channels 0 and 1 both hold read valid, transport ready=1:
  - grants alternate 0,1,0,1; rr_q toggles.
  - write side accepts only ch0 then ch1, even if ch1 write is valid first.
- Read stall: ch1 valid, r_dp_ready_i=0 for 3 cycles while ch0 raises valid:
  - grant and r_dp_req_o stay on ch1 until ready.
  - ch0 is granted next.
- OrderDepth=4, writes held invalid: 4 reads from ch0 accepted.
  - 5th read sees ready=0.
  - after one write handshake, the 5th read is accepted one cycle later.
- Responses: issue reads ch1,ch0,ch1, return 3 responses:
  - chan_r_rsp_valid_o sequence is 0b10, 0b01, 0b10.
  - holding chan_r_rsp_ready_i[1]=0 stalls r_dp_rsp_ready_o.
- Simultaneous push/pop on a full order FIFO is blocked:
  - with 4 entries, a read is refused while a write pops; the read is accepted next cycle.
  - count stays at 4.
- Assert rst_i with 2 entries outstanding and a locked grant:
  - all outputs 0 immediately.
  - after release, the first grant goes to ch0 and busy_o=0 until a new request arrives.
